booth8_seq_mul: RTL and testbench
=================================

Name: booth8_seq_mul

Overview:
- Parametrised, iterative radix-8 Booth multiplier for WIDTH x WIDTH operands, in signed or unsigned mode selected per operation.
- Retires one radix-8 digit (3 multiplier bits) per clock using shift-add, with a registered 3X multiple computed once per operation.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths.
- Successor to the combinational fixed 8-bit unsigned radix-8 compute unit: it trades area for latency and adds signed mode, backpressure and width scaling.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- NDIG (localparam), ceil((WIDTH+1)/3), number of radix-8 digits processed per operation.

Ports:
- iClk  input  1  clock; all state updates on its rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  operand pair valid.
- oReady  output  1  block can accept operands.
- iSigned  input  1  1 = two's-complement operands, 0 = unsigned; captured at accept.
- iDatA  input  WIDTH  multiplicand.
- iDatB  input  WIDTH  multiplier.
- oValid  output  1  product valid.
- iReady  input  1  downstream accepts product.
- oDat  output  2*WIDTH  product.
- oBusy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (iRst sampled high at a clock edge), effective next cycle:
  - state = IDLE.
  - oValid = 0, oDat = 0, oBusy = 0, oReady = 1.
  - Internal accumulator and counter cleared.
  - Reset mid-operation aborts the operation; the result is discarded and never presented.
- States: IDLE, PREP, ITER, DONE.
- IDLE:
  - oReady = 1.
  - On iValid & oReady, capture iDatA, iDatB and iSigned, then go to PREP.
  - iValid without acceptance has no effect.
- PREP (1 cycle):
  - Extend A to WIDTH+1 bits: sign-extend if signed, zero-extend if unsigned.
  - Register 3A (WIDTH+3 bits).
  - Extend B to 3*NDIG bits the same way and append an implicit 0 below bit 0.
  - Clear the accumulator and set digit counter = 0. Go to ITER.
- ITER (exactly NDIG cycles):
  - Digit k is formed from B bits [3k+2 : 3k-1] and recoded to d in {-4..+4}.
  - The selected multiple (0, ±A, ±2A, ±3A, ±4A) is added to the accumulator high part.
  - The accumulator then shifts arithmetically right by 3.
  - On the last digit, go to DONE and load oDat.
- DONE:
  - oValid = 1 and oDat holds the product.
  - oDat stays stable while iReady = 0, for any number of cycles.
  - On iReady = 1, oValid drops next cycle and state returns to IDLE.
- oReady is 0 in PREP, ITER and DONE. No accept is possible in the same cycle as product handoff.
- Latency: accept at cycle t gives oValid high at cycle t+NDIG+2; that is 5 cycles for WIDTH=8.
- Throughput: one product per NDIG+3 cycles when iReady is held high.
- Arithmetic:
  - oDat equals the exact product of the interpreted operands, modulo 2^(2*WIDTH).
  - The product is two's complement when signed.
  - Internal accumulator width is at least 2*WIDTH+4 bits so no intermediate overflow occurs.
- Operands at ports are ignored except in the accept cycle. Changes to iSigned after accept have no effect.
- iReady while oValid = 0 is ignored.

Decomposition:
- Package booth8_pkg holds:
  - the state enum typedef (IDLE, PREP, ITER, DONE);
  - a function returning NDIG for a given WIDTH;
  - a digit-recode typedef (sign, magnitude 0..4).
- Sub-module booth8_digit_sel, purely combinational:
  - Inputs: 4-bit Booth window, A, 3A.
  - Output: the signed selected multiple, WIDTH+4 bits.
  - Instantiated once; the top block holds the FSM, counter, accumulator and handshakes.

Test Plan:
- WIDTH=8, unsigned, A=0xFF, B=0xFF, iReady=1 -> oValid high exactly 5 cycles after accept; oDat=0xFE01; oReady returns to 1 one cycle after the handoff cycle.
- WIDTH=8, signed, A=0x80, B=0x80 -> oDat=0x4000. Signed A=0x80, B=0x7F -> oDat=0xC080. Signed A=0xFF, B=0x01 -> oDat=0xFFFF.
- Backpressure: unsigned 0x12 x 0x34, iReady=0 for 4 cycles after oValid -> oValid stays 1 and oDat holds 0x03A8; oReady stays 0; the iValid pulse offered during this time is not accepted.
- Reset mid-ITER: accept 0xAB x 0xCD, assert iRst on the 2nd ITER cycle -> next cycle oValid=0, oDat=0, oBusy=0, oReady=1; no product ever appears.
- WIDTH=16 build, unsigned 0xFFFF x 0xFFFF -> oDat=0xFFFE0001 at latency 8 (NDIG=6). Signed 0x8000 x 0x8000 -> oDat=0x40000000.
- Random regression on WIDTH in {4,8,13,16}: 10k operand pairs, mixed iSigned, random iValid/iReady gaps -> every oDat matches the reference model, and the product count equals the accept count.

Source files
------------

// File: rtl/booth8_pkg.sv
// booth8_pkg: shared types and helpers for the sequential radix-8 Booth multiplier.
//   booth8_state_e  - control FSM states
//   booth8_digit_t  - recoded Booth digit (sign + magnitude 0..4)
//   booth8_ndig()   - number of radix-8 digits for a given operand width
//   booth8_recode() - maps a 4-bit Booth window to a signed digit
package booth8_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrep,
    StIter,
    StDone
  } booth8_state_e;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } booth8_digit_t;

  // ceil((width + 1) / 3): one extra bit so the top digit sees the extension bit.
  function automatic int unsigned booth8_ndig(input int unsigned width);
    return (width + 3) / 3;
  endfunction

  // Window {b[3k+2], b[3k+1], b[3k], b[3k-1]} -> -4*b2 + 2*b1 + b0 + b-1.
  function automatic booth8_digit_t booth8_recode(input logic [3:0] win);
    booth8_digit_t dig;
    dig.neg = win[3];
    case (win)
      4'b0000, 4'b1111:                   dig.mag = 3'd0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: dig.mag = 3'd1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: dig.mag = 3'd2;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: dig.mag = 3'd3;
      4'b0111, 4'b1000:                   dig.mag = 3'd4;
      default:                            dig.mag = 3'd0;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth8_digit_sel.sv
// booth8_digit_sel: combinational Booth multiple selector.
// Ports:
//   window - 4-bit Booth window {b[3k+2:3k], b[3k-1]}
//   a      - multiplicand extended to WIDTH+1 bits (two's complement)
//   a3     - registered 3*a, WIDTH+3 bits (two's complement)
//   mult   - selected multiple d*a, d in -4..+4, WIDTH+4 bits (two's complement)
module booth8_digit_sel
  import booth8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       window,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH+2:0] a3,
  output logic [WIDTH+3:0] mult
);

  booth8_digit_t    dig;
  logic [WIDTH+3:0] a_x;
  logic [WIDTH+3:0] a3_x;
  logic [WIDTH+3:0] mag;

  always_comb begin
    dig  = booth8_recode(window);
    a_x  = {{3{a[WIDTH]}}, a};
    a3_x = {a3[WIDTH+2], a3};
    case (dig.mag)
      3'd1:    mag = a_x;
      3'd2:    mag = {a_x[WIDTH+2:0], 1'b0};
      3'd3:    mag = a3_x;
      3'd4:    mag = {a_x[WIDTH+1:0], 2'b00};
      default: mag = '0;
    endcase
    mult = dig.neg ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/booth8_seq_mul.sv
// booth8_seq_mul: iterative radix-8 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
// signed or unsigned per operation, one digit retired per clock.
// Ports:
//   iClk, iRst         - clock, synchronous active-high reset
//   iValid/oReady      - operand handshake; iDatA (multiplicand), iDatB (multiplier),
//                        iSigned captured on accept
//   oValid/iReady      - product handshake; oDat holds the product while oValid
//   oBusy              - high whenever an operation is in flight or awaiting handoff
module booth8_seq_mul
  import booth8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iValid,
  output logic               oReady,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iDatA,
  input  logic [WIDTH-1:0]   iDatB,
  output logic               oValid,
  input  logic               iReady,
  output logic [2*WIDTH-1:0] oDat,
  output logic               oBusy
);

  localparam int unsigned NDIG = booth8_ndig(WIDTH);
  localparam int unsigned LW   = 3 * NDIG;  // low accumulator part / extended B width
  localparam int unsigned HW   = WIDTH + 4; // high accumulator part / multiple width
  localparam int unsigned AW   = HW + LW;
  localparam int unsigned CW   = 4;         // NDIG <= 11 for WIDTH <= 32

  booth8_state_e      state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;
  logic [WIDTH+2:0]   a3_q;
  logic [LW:0]        bsh_q;
  logic [AW-1:0]      acc_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] dat_q;

  logic               last_dig;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH+2:0]   a_ext3;
  logic [WIDTH+2:0]   a3_calc;
  logic [LW:0]        b_ext;
  logic [HW-1:0]      mult;
  logic [HW-1:0]      acc_hi_sum;
  logic [AW-1:0]      acc_step;
  logic [AW-1:0]      acc_shift;

  // Control FSM.
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    oReady   = 1'b0;
    oValid   = 1'b0;
    oBusy    = 1'b1;
    last_dig = (cnt_q == CW'(NDIG - 1));
    unique case (state_q)
      StIdle: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        if (iValid) state_d = StPrep;
      end
      StPrep: state_d = StIter;
      StIter: if (last_dig) state_d = StDone;
      StDone: begin
        oValid = 1'b1;
        if (iReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand extension and per-digit accumulate/shift.
  always_comb begin
    a_ext      = {sgn_q & a_q[WIDTH-1], a_q};
    a_ext3     = {{2{a_ext[WIDTH]}}, a_ext};
    a3_calc    = a_ext3 + {a_ext3[WIDTH+1:0], 1'b0};
    // Implicit zero below bit 0 seeds the first Booth window.
    b_ext      = {{(LW - WIDTH){sgn_q & b_q[WIDTH-1]}}, b_q, 1'b0};
    acc_hi_sum = acc_q[AW-1 -: HW] + mult;
    acc_step   = {acc_hi_sum, acc_q[LW-1:0]};
    acc_shift  = {{3{acc_step[AW-1]}}, acc_step[AW-1:3]};
  end

  booth8_digit_sel #(
    .WIDTH(WIDTH)
  ) u_digit_sel (
    .window(bsh_q[3:0]),
    .a     (a_ext),
    .a3    (a3_q),
    .mult  (mult)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      a3_q  <= '0;
      bsh_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iValid) begin
            a_q   <= iDatA;
            b_q   <= iDatB;
            sgn_q <= iSigned;
          end
        end
        StPrep: begin
          a3_q  <= a3_calc;
          bsh_q <= b_ext;
          acc_q <= '0;
          cnt_q <= '0;
        end
        StIter: begin
          acc_q <= acc_shift;
          bsh_q <= bsh_q >> 3;
          cnt_q <= cnt_q + CW'(1);
          if (last_dig) dat_q <= acc_shift[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign oDat = dat_q;

endmodule

// File: tb/tb_booth8_seq_mul.sv
// Bench for booth8_seq_mul: 8-bit and 16-bit instances, directed corner cases plus a
// randomised scoreboard run with valid/ready gaps.
module tb_booth8_seq_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8, s8, r8, rdy8, ov8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] d8;
  logic        v16, s16, r16, rdy16, ov16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] d16;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc8   = 0;
  int n_prod8  = 0;
  int n_acc16  = 0;
  int n_prod16 = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];

  booth8_seq_mul #(.WIDTH(8)) u_dut8 (
    .iClk(clk), .iRst(rst), .iValid(v8), .oReady(rdy8), .iSigned(s8), .iDatA(a8),
    .iDatB(b8), .oValid(ov8), .iReady(r8), .oDat(d8), .oBusy(busy8)
  );

  booth8_seq_mul #(.WIDTH(16)) u_dut16 (
    .iClk(clk), .iRst(rst), .iValid(v16), .oReady(rdy16), .iSigned(s16), .iDatA(a16),
    .iDatB(b16), .oValid(ov16), .iReady(r16), .oDat(d16), .oBusy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the interpreted operands, modulo 2^(2w).
  function automatic logic [63:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    longint      ax, bx;
    logic [31:0] m;
    logic [63:0] mask;
    m  = (32'd1 << w) - 1;
    ax = longint'({32'b0, a & m});
    bx = longint'({32'b0, b & m});
    if (s && a[w-1]) ax = ax - (longint'(1) << w);
    if (s && b[w-1]) bx = bx - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 1;
    return 64'(ax * bx) & mask;
  endfunction

  function automatic logic [31:0] pick(input int unsigned w);
    logic [31:0] r, m;
    m = (32'd1 << w) - 1;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = m;
      2:       r = 32'd1 << (w - 1);
      3:       r = (32'd1 << (w - 1)) - 1;
      default: ;
    endcase
    return r & m;
  endfunction

  // Product monitors: a handoff happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && ov8 && r8) begin
      check("sb8_pending", 64'(q8.size() != 0), 1);
      if (q8.size() != 0) check("sb8_dat", d8, q8.pop_front());
      n_prod8++;
    end
    if (!rst && ov16 && r16) begin
      check("sb16_pending", 64'(q16.size() != 0), 1);
      if (q16.size() != 0) check("sb16_dat", d16, q16.pop_front());
      n_prod16++;
    end
  end

  task automatic start_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp);
    if (wide) begin
      check("start16_rdy", rdy16, 1);
      v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; s16 = s;
      q16.push_back(exp);
      n_acc16++;
    end else begin
      check("start8_rdy", rdy8, 1);
      v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
      q8.push_back(exp[15:0]);
      n_acc8++;
    end
  endtask

  // Count cycles from the accept cycle until oValid is seen.
  task automatic wait_done(input bit wide, input int exp_lat);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      v8  = 1'b0;
      v16 = 1'b0;
      lat++;
      seen = wide ? ov16 : ov8;
    end
    if (wide) check("lat16", lat, exp_lat);
    else      check("lat8", lat, exp_lat);
  endtask

  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp, input int lat);
    start_op(wide, a, b, s, exp);
    wait_done(wide, lat);
    @(posedge clk); #1;
  endtask

  task automatic rand8();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      v8 = ($urandom_range(0, 2) != 0);
      a8 = 8'(pick(8));
      b8 = 8'(pick(8));
      s8 = 1'($urandom_range(0, 1));
      r8 = ($urandom_range(0, 3) != 0);
      if (v8 && rdy8) begin
        q8.push_back(16'(model(8, {24'b0, a8}, {24'b0, b8}, s8)));
        n_acc8++;
      end
    end
  endtask

  task automatic rand16();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      v16 = ($urandom_range(0, 2) != 0);
      a16 = 16'(pick(16));
      b16 = 16'(pick(16));
      s16 = 1'($urandom_range(0, 1));
      r16 = ($urandom_range(0, 3) != 0);
      if (v16 && rdy16) begin
        q16.push_back(32'(model(16, {16'b0, a16}, {16'b0, b16}, s16)));
        n_acc16++;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    v8 = 0; s8 = 0; r8 = 1; a8 = '0; b8 = '0;
    v16 = 0; s16 = 0; r16 = 1; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov8", ov8, 0);
    check("rst_dat8", d8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_rdy8", rdy8, 1);
    check("rst_ov16", ov16, 0);
    check("rst_busy16", busy16, 0);
    check("rst_rdy16", rdy16, 1);
    rst = 1'b0;

    // Full-scale unsigned: latency and ready return after handoff.
    start_op(0, 32'hFF, 32'hFF, 1'b0, 32'hFE01);
    wait_done(0, 5);
    check("done_rdy8", rdy8, 0);
    check("done_busy8", busy8, 1);
    @(posedge clk); #1;
    check("handoff_ov8", ov8, 0);
    check("handoff_rdy8", rdy8, 1);

    run_op(0, 32'h80, 32'h80, 1'b1, 32'h4000, 5);
    run_op(0, 32'h80, 32'h7F, 1'b1, 32'hC080, 5);
    run_op(0, 32'hFF, 32'h01, 1'b1, 32'hFFFF, 5);

    // Backpressure: product held, offered operands refused.
    r8 = 1'b0;
    start_op(0, 32'h12, 32'h34, 1'b0, 32'h03A8);
    wait_done(0, 5);
    for (int i = 0; i < 4; i++) begin
      check("bp_ov8", ov8, 1);
      check("bp_dat8", d8, 16'h03A8);
      check("bp_rdy8", rdy8, 0);
      v8 = 1'b1; a8 = 8'h55; b8 = 8'h66; s8 = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_ov8_end", ov8, 1);
    v8 = 1'b0;
    r8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov8", ov8, 0);

    // Reset during the second ITER cycle aborts the operation.
    start_op(0, 32'hAB, 32'hCD, 1'b0, 32'(model(8, 32'hAB, 32'hCD, 1'b0)));
    @(posedge clk); #1;   // PREP
    v8 = 1'b0;
    @(posedge clk); #1;   // first ITER
    @(posedge clk); #1;   // second ITER
    check("abort_busy8", busy8, 1);
    rst = 1'b1;
    n_acc8 -= q8.size();
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ov8", ov8, 0);
    check("abort_dat8", d8, 0);
    check("abort_busy8_clr", busy8, 0);
    check("abort_rdy8", rdy8, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_prod8", ov8, 0);
    end

    // 16-bit build.
    run_op(1, 32'hFFFF, 32'hFFFF, 1'b0, 32'hFFFE0001, 8);
    run_op(1, 32'h8000, 32'h8000, 1'b1, 32'h40000000, 8);

    fork
      rand8();
      rand16();
    join

    v8 = 1'b0; v16 = 1'b0; r8 = 1'b1; r16 = 1'b1;
    for (int i = 0; i < 100 && (q8.size() != 0 || q16.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain8_left", q8.size(), 0);
    check("drain16_left", q16.size(), 0);
    check("count8", n_prod8, n_acc8);
    check("count16", n_prod16, n_acc16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
